vending_machine_top: RTL and testbench

- Single-clock vending-machine controller.
- Accepts coin counts each cycle and tracks credit in quarter units ($0.25).
- Lets the user select one of four items, dispenses on `in_next` when credit covers the price, and pays out the remaining credit as coins on `in_finish`.
- Sits between the coin/button front-end and the dispenser/coin-return actuators.

---
 rtl/vending_machine_top_if.sv | 39 +++
 rtl/vending_machine_top.sv | 130 +++++++++++++
 tb/tb_vending_machine_top.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_top_if.sv
// Front-end / actuator bundle for the vending-machine controller.
// The master side (coin acceptor, buttons) drives in_*; the slave side
// (controller) drives out_* toward the dispenser and coin return.
interface vending_machine_top_if;
  logic [7:0]        in_inserted_5;
  logic [7:0]        in_inserted_1;
  logic [7:0]        in_inserted_05;
  logic [7:0]        in_inserted_025;
  logic              in_sel_a, in_sel_b, in_sel_c, in_sel_d;
  logic              in_next;
  logic              in_finish;

  logic signed [15:0] out_change;
  logic              out_stock_a, out_stock_b, out_stock_c, out_stock_d;
  logic              out_csel_a, out_csel_b, out_csel_c, out_csel_d;
  logic [7:0]        out_change_1;
  logic              out_change_05;
  logic              out_change_025;
  logic              out_spit_a, out_spit_b, out_spit_c, out_spit_d;
  logic [1:0]        out_state;

  modport master (
    output in_inserted_5, in_inserted_1, in_inserted_05, in_inserted_025,
    output in_sel_a, in_sel_b, in_sel_c, in_sel_d, in_next, in_finish,
    input  out_change, out_stock_a, out_stock_b, out_stock_c, out_stock_d,
    input  out_csel_a, out_csel_b, out_csel_c, out_csel_d,
    input  out_change_1, out_change_05, out_change_025,
    input  out_spit_a, out_spit_b, out_spit_c, out_spit_d, out_state
  );

  modport slave (
    input  in_inserted_5, in_inserted_1, in_inserted_05, in_inserted_025,
    input  in_sel_a, in_sel_b, in_sel_c, in_sel_d, in_next, in_finish,
    output out_change, out_stock_a, out_stock_b, out_stock_c, out_stock_d,
    output out_csel_a, out_csel_b, out_csel_c, out_csel_d,
    output out_change_1, out_change_05, out_change_025,
    output out_spit_a, out_spit_b, out_spit_c, out_spit_d, out_state
  );
endinterface

// File: rtl/vending_machine_top.sv
// Vending-machine controller: credit in quarters, four items with stock
// counters, dispense on next, coin change on finish. All outputs come
// straight from registers (or from register-only arithmetic).
module vending_machine_top #(
  parameter int PRICE_A    = 4,
  parameter int PRICE_B    = 6,
  parameter int PRICE_C    = 8,
  parameter int PRICE_D    = 12,
  parameter int STOCK_INIT = 10
) (
  input  logic                 in_clka,
  input  logic                 in_restart,
  vending_machine_top_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SELECTED = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_t;

  localparam logic [16:0] CREDIT_MAX = 17'd32767;

  // Item index 0..3 = a..d throughout.
  logic [3:0][15:0] price;
  assign price = {16'(PRICE_D), 16'(PRICE_C), 16'(PRICE_B), 16'(PRICE_A)};

  state_t         state_q, state_d;
  logic [15:0]    credit_q, credit_d;
  logic [3:0]     sel_q, sel_d;          // one-hot, 0 = nothing selected
  logic [3:0][7:0] stock_q, stock_d;
  logic [3:0]     spit_q, spit_d;
  logic [7:0]     chg1_q, chg1_d;
  logic           chg05_q, chg05_d, chg025_q, chg025_d;

  logic [16:0]    coin_val, credit_sum;
  logic [15:0]    credit_add, sel_price;
  logic [3:0]     stock_nz, btn, pick;

  assign btn = {bus.in_sel_d, bus.in_sel_c, bus.in_sel_b, bus.in_sel_a};

  // Coin value, saturating credit, selection decode and selected price.
  always_comb begin
    coin_val = 17'(bus.in_inserted_5)  * 17'd20 + 17'(bus.in_inserted_1) * 17'd4
             + 17'(bus.in_inserted_05) * 17'd2  + 17'(bus.in_inserted_025);
    // Coins arriving while change is being paid are not credited.
    credit_sum = (state_q == CHANGE) ? 17'(credit_q) : 17'(credit_q) + coin_val;
    credit_add = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[15:0] : credit_sum[15:0];
    // Highest-priority pressed button wins; if that item is sold out the press is dropped.
    pick = 4'b0000;
    if      (btn[0]) pick = 4'b0001;
    else if (btn[1]) pick = 4'b0010;
    else if (btn[2]) pick = 4'b0100;
    else if (btn[3]) pick = 4'b1000;
    sel_price = 16'd0;
    for (int i = 0; i < 4; i++) begin
      stock_nz[i] = (stock_q[i] != 8'd0);
      if (sel_q[i]) sel_price = price[i];
    end
  end

  // Next-state logic: finish beats next beats select.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_add;
    sel_d    = sel_q;
    stock_d  = stock_q;
    spit_d   = 4'b0000;
    chg1_d   = 8'd0;
    chg05_d  = 1'b0;
    chg025_d = 1'b0;
    case (state_q)
      IDLE, SELECTED: begin
        if (bus.in_finish) begin
          state_d  = CHANGE;
          chg1_d   = (|credit_add[15:10]) ? 8'hFF : credit_add[9:2];
          chg05_d  = credit_add[1];
          chg025_d = credit_add[0];
          credit_d = 16'd0;
          sel_d    = 4'b0000;
        end else if (bus.in_next && state_q == SELECTED && credit_add >= sel_price) begin
          state_d  = DISPENSE;
          credit_d = credit_add - sel_price;
          spit_d   = sel_q;
          sel_d    = 4'b0000;
          for (int i = 0; i < 4; i++)
            if (sel_q[i]) stock_d[i] = stock_q[i] - 8'd1;
        end else if (|(pick & stock_nz)) begin
          state_d = SELECTED;
          sel_d   = pick;
        end
      end
      DISPENSE: state_d = IDLE;
      CHANGE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any session without paying change.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state_q  <= IDLE;
      credit_q <= 16'd0;
      sel_q    <= 4'b0000;
      stock_q  <= {4{8'(STOCK_INIT)}};
      spit_q   <= 4'b0000;
      chg1_q   <= 8'd0;
      chg05_q  <= 1'b0;
      chg025_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      stock_q  <= stock_d;
      spit_q   <= spit_d;
      chg1_q   <= chg1_d;
      chg05_q  <= chg05_d;
      chg025_q <= chg025_d;
    end
  end

  assign bus.out_change     = credit_q - sel_price;
  assign bus.out_state      = state_q;
  assign {bus.out_stock_d, bus.out_stock_c, bus.out_stock_b, bus.out_stock_a} = stock_nz;
  assign {bus.out_csel_d, bus.out_csel_c, bus.out_csel_b, bus.out_csel_a}     = sel_q;
  assign {bus.out_spit_d, bus.out_spit_c, bus.out_spit_b, bus.out_spit_a}     = spit_q;
  assign bus.out_change_1   = chg1_q;
  assign bus.out_change_05  = chg05_q;
  assign bus.out_change_025 = chg025_q;
endmodule

// File: tb/tb_vending_machine_top.sv
// Bench for vending_machine_top: directed vector table, hand-written corner
// sequences, and random traffic against a quarter-arithmetic reference model.
module tb_vending_machine_top;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vending_machine_top_if bus ();
  vending_machine_top dut (.in_clka(clk), .in_restart(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         n5, n1, n05, n025;
    logic [3:0] sel;            // bit0 = a
    logic       nx, fn;
    int         ch;
    int         st;
    logic [3:0] cs, sp;
    int         c1;
    logic       c05, c025;
  } vec_t;

  function automatic vec_t mk(int n5, int n1, int n05, int n025, logic [3:0] sel,
                              logic nx, logic fn, int ch, int st, logic [3:0] cs,
                              logic [3:0] sp, int c1, logic c05, logic c025);
    vec_t v;
    v.n5 = n5; v.n1 = n1; v.n05 = n05; v.n025 = n025; v.sel = sel; v.nx = nx; v.fn = fn;
    v.ch = ch; v.st = st; v.cs = cs; v.sp = sp; v.c1 = c1; v.c05 = c05; v.c025 = c025;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input int ch, input int st, input logic [3:0] cs,
                           input logic [3:0] sp, input int c1, input logic c05,
                           input logic c025, input logic [3:0] stk);
    chk({tag, " change"}, int'($signed(bus.out_change)), ch);
    chk({tag, " state"}, int'(bus.out_state), st);
    chk({tag, " csel"}, int'({bus.out_csel_d, bus.out_csel_c, bus.out_csel_b, bus.out_csel_a}), int'(cs));
    chk({tag, " spit"}, int'({bus.out_spit_d, bus.out_spit_c, bus.out_spit_b, bus.out_spit_a}), int'(sp));
    chk({tag, " change_1"}, int'(bus.out_change_1), c1);
    chk({tag, " change_05"}, int'(bus.out_change_05), int'(c05));
    chk({tag, " change_025"}, int'(bus.out_change_025), int'(c025));
    chk({tag, " stock"}, int'({bus.out_stock_d, bus.out_stock_c, bus.out_stock_b, bus.out_stock_a}), int'(stk));
  endtask

  task automatic apply(input int n5, input int n1, input int n05, input int n025,
                       input logic [3:0] sel, input logic nx, input logic fn);
    bus.in_inserted_5   = 8'(n5);
    bus.in_inserted_1   = 8'(n1);
    bus.in_inserted_05  = 8'(n05);
    bus.in_inserted_025 = 8'(n025);
    {bus.in_sel_d, bus.in_sel_c, bus.in_sel_b, bus.in_sel_a} = sel;
    bus.in_next   = nx;
    bus.in_finish = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(0, 0, 0, 0, 4'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Reference model: credit in quarters, selected item index, per-item stock.
  int m_credit, m_sel, m_phase, m_c1;
  int m_stock[4];
  logic [3:0] m_spit;
  logic m_c05, m_c025;
  int prices[4] = '{4, 6, 8, 12};

  task automatic model_reset();
    m_credit = 0; m_sel = -1; m_phase = 0; m_spit = 0; m_c1 = 0; m_c05 = 0; m_c025 = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 10;
  endtask

  task automatic model_step(input int n5, input int n1, input int n05, input int n025,
                            input logic [3:0] sel, input logic nx, input logic fn);
    int first;
    m_spit = 0; m_c1 = 0; m_c05 = 0; m_c025 = 0;
    if (m_phase == 3) begin
      m_phase = 0;
    end else begin
      m_credit = m_credit + 20 * n5 + 4 * n1 + 2 * n05 + n025;
      if (m_credit > 32767) m_credit = 32767;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (fn) begin
        m_c1 = (m_credit / 4 > 255) ? 255 : m_credit / 4;
        m_c05 = m_credit[1];
        m_c025 = m_credit[0];
        m_credit = 0; m_sel = -1; m_phase = 3;
      end else if (nx && m_phase == 1 && m_credit >= prices[m_sel]) begin
        m_credit -= prices[m_sel];
        m_stock[m_sel]--;
        m_spit = 4'(1 << m_sel);
        m_sel = -1; m_phase = 2;
      end else if (sel != 0) begin
        first = 3;
        for (int i = 3; i >= 0; i--) if (sel[i]) first = i;
        if (m_stock[first] > 0) begin m_sel = first; m_phase = 1; end
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] stk;
    for (int i = 0; i < 4; i++) stk[i] = (m_stock[i] != 0);
    check_all(tag, (m_sel < 0) ? m_credit : m_credit - prices[m_sel], m_phase,
              (m_sel < 0) ? 4'b0 : 4'(1 << m_sel), m_spit, m_c1, m_c05, m_c025, stk);
  endtask

  vec_t vecs[20];

  initial begin
    // Directed session walk-through (state/credit expectations in quarters).
    vecs[0]  = mk(0,0,0,0, 4'b0000, 0,0,   0, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[1]  = mk(0,0,0,0, 4'b0001, 0,0,  -4, 1, 4'b0001, 4'b0000, 0,0,0);
    vecs[2]  = mk(0,1,1,0, 4'b0000, 0,0,   2, 1, 4'b0001, 4'b0000, 0,0,0);
    vecs[3]  = mk(0,1,0,0, 4'b0000, 0,0,   6, 1, 4'b0001, 4'b0000, 0,0,0);
    vecs[4]  = mk(0,0,0,0, 4'b0000, 1,0,   6, 2, 4'b0000, 4'b0001, 0,0,0);
    vecs[5]  = mk(0,0,0,0, 4'b0000, 0,0,   6, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[6]  = mk(1,0,0,0, 4'b0100, 0,0,  18, 1, 4'b0100, 4'b0000, 0,0,0);
    vecs[7]  = mk(0,0,0,0, 4'b0000, 1,0,  18, 2, 4'b0000, 4'b0100, 0,0,0);
    vecs[8]  = mk(0,0,0,0, 4'b0000, 0,0,  18, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[9]  = mk(0,0,0,0, 4'b0000, 0,1,   0, 3, 4'b0000, 4'b0000, 4,1,0);
    vecs[10] = mk(0,0,0,0, 4'b0000, 0,0,   0, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[11] = mk(0,1,0,0, 4'b0000, 0,0,   4, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[12] = mk(0,0,0,0, 4'b1000, 0,0,  -8, 1, 4'b1000, 4'b0000, 0,0,0);
    vecs[13] = mk(0,0,0,0, 4'b0000, 1,0,  -8, 1, 4'b1000, 4'b0000, 0,0,0);
    vecs[14] = mk(0,0,0,0, 4'b0010, 0,0,  -2, 1, 4'b0010, 4'b0000, 0,0,0);
    vecs[15] = mk(0,0,1,0, 4'b0000, 1,0,   0, 2, 4'b0000, 4'b0010, 0,0,0);
    vecs[16] = mk(0,0,0,1, 4'b0001, 0,0,   1, 0, 4'b0000, 4'b0000, 0,0,0);
    vecs[17] = mk(0,2,0,0, 4'b0001, 0,0,   5, 1, 4'b0001, 4'b0000, 0,0,0);
    vecs[18] = mk(0,0,0,0, 4'b0001, 1,1,   0, 3, 4'b0000, 4'b0000, 2,0,1);
    vecs[19] = mk(1,0,0,0, 4'b0000, 0,0,   0, 0, 4'b0000, 4'b0000, 0,0,0);

    do_reset();
    check_all("reset", 0, 0, 4'b0, 4'b0, 0, 1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].n5, vecs[i].n1, vecs[i].n05, vecs[i].n025, vecs[i].sel, vecs[i].nx, vecs[i].fn);
      check_all($sformatf("vec%0d", i), vecs[i].ch, vecs[i].st, vecs[i].cs, vecs[i].sp,
                vecs[i].c1, vecs[i].c05, vecs[i].c025, 4'hF);
    end

    // Sell out item A from a fresh reset.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(0, 1, 0, 0, 4'b0001, 1'b0, 1'b0);
      apply(0, 0, 0, 0, 4'b0000, 1'b1, 1'b0);
      chk($sformatf("sellout%0d spit_a", k), int'(bus.out_spit_a), 1);
      chk($sformatf("sellout%0d stock_a", k), int'(bus.out_stock_a), (k < 9) ? 1 : 0);
      apply(0, 0, 0, 0, 4'b0000, 1'b0, 1'b0);
    end
    apply(0, 1, 0, 0, 4'b0001, 1'b0, 1'b0);
    chk("soldout csel_a", int'(bus.out_csel_a), 0);
    chk("soldout state", int'(bus.out_state), 0);
    chk("soldout credit", int'($signed(bus.out_change)), 4);

    // Credit saturation and change-coin saturation.
    do_reset();
    for (int k = 0; k < 7; k++) apply(255, 0, 0, 0, 4'b0, 1'b0, 1'b0);
    chk("sat credit", int'($signed(bus.out_change)), 32767);
    apply(0, 0, 0, 0, 4'b0, 1'b0, 1'b1);
    chk("sat change_1", int'(bus.out_change_1), 255);
    chk("sat change_05", int'(bus.out_change_05), 1);
    chk("sat change_025", int'(bus.out_change_025), 1);
    apply(0, 0, 0, 0, 4'b0, 1'b0, 1'b0);
    chk("sat after change_1", int'(bus.out_change_1), 0);

    // Asynchronous reset mid-session clears everything before any clock edge.
    apply(0, 3, 0, 0, 4'b0100, 1'b0, 1'b0);
    chk("pre-abort state", int'(bus.out_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort state", int'(bus.out_state), 0);
    chk("abort change", int'($signed(bus.out_change)), 0);
    chk("abort csel_c", int'(bus.out_csel_c), 0);
    chk("abort change_1", int'(bus.out_change_1), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      int n5, n1, n05, n025;
      logic [3:0] sel;
      logic nx, fn;
      n5   = ($urandom_range(0, 9) == 0) ? 1 : 0;
      n1   = $urandom_range(0, 2);
      n05  = $urandom_range(0, 1);
      n025 = $urandom_range(0, 1);
      sel  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      nx   = ($urandom_range(0, 2) == 0);
      fn   = ($urandom_range(0, 15) == 0);
      apply(n5, n1, n05, n025, sel, nx, fn);
      model_step(n5, n1, n05, n025, sel, nx, fn);
      model_check($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
